// File: rtl/shared_dram_arb.sv
// Single-bank data memory shared by NUM_PORTS cores through req/ack handshakes.
// A round-robin arbiter grants one access per cycle; writes are synchronous, reads registered.
module shared_dram_arb #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
    output logic [NUM_PORTS-1:0]          ack,
    output logic [NUM_PORTS*DATA_W-1:0]   rdata,
    output logic [NUM_PORTS-1:0]          addr_err
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0]    mem [DEPTH];

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     next_ptr_c;
    logic [PTR_W-1:0]     cand_c;
    logic [NUM_PORTS-1:0] elig_c;
    logic [NUM_PORTS-1:0] gnt_c;
    logic                 gnt_vld_c;
    logic                 sel_we_c;
    logic [ADDR_W-1:0]    sel_addr_c;
    logic [DATA_W-1:0]    sel_wdata_c;
    logic                 in_range_c;
    logic [IDX_W-1:0]     mem_idx_c;
    logic                 wr_en_c;

    // Round-robin scan starting at rr_ptr; a port just acked is masked for one cycle.
    always_comb begin
        elig_c    = req & ~ack;
        gnt_c     = '0;
        gnt_vld_c = 1'b0;
        cand_c    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand_c = PTR_W'((32'(rr_ptr) + 32'(i)) % NUM_PORTS);
            if (!gnt_vld_c && elig_c[cand_c]) begin
                gnt_c[cand_c] = 1'b1;
                gnt_vld_c     = 1'b1;
            end
        end
    end

    // Mux the granted port's command and derive the next pointer.
    always_comb begin
        sel_we_c    = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        next_ptr_c  = rr_ptr;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_c[p]) begin
                sel_we_c    = we[p];
                sel_addr_c  = addr[p*ADDR_W +: ADDR_W];
                sel_wdata_c = wdata[p*DATA_W +: DATA_W];
                next_ptr_c  = PTR_W'((p + 1) % NUM_PORTS);
            end
        end
        in_range_c = (32'(sel_addr_c) < DEPTH);
        mem_idx_c  = sel_addr_c[IDX_W-1:0];
        wr_en_c    = gnt_vld_c & sel_we_c & in_range_c;
    end

    // Storage is intentionally not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[mem_idx_c] <= sel_wdata_c;
        end
    end

    // Handshake, error flag, per-port read data and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            ack      <= '0;
            addr_err <= '0;
            rdata    <= '0;
        end else begin
            rr_ptr   <= next_ptr_c;
            ack      <= gnt_c;
            addr_err <= in_range_c ? '0 : gnt_c;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (gnt_c[p] && !sel_we_c) begin
                    rdata[p*DATA_W +: DATA_W] <= in_range_c ? mem[mem_idx_c] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_shared_dram_arb.sv
// Directed bench for shared_dram_arb: reset, round-robin order, masking, range errors,
// cross-port write/read forwarding through memory, and reset during contention.
module tb_shared_dram_arb;

    localparam int NP = 4;
    localparam int DW = 16;
    localparam int AW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     req;
    logic [NP-1:0]     we;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  wdata;
    logic [NP-1:0]     ack;
    logic [NP*DW-1:0]  rdata;
    logic [NP-1:0]     addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    shared_dram_arb #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .DEPTH     (1024),
        .NUM_PORTS (NP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .ack      (ack),
        .rdata    (rdata),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return rdata[p*DW +: DW];
    endfunction

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[p]            = r;
        we[p]             = w;
        addr[p*AW +: AW]  = a;
        wdata[p*DW +: DW] = d;
    endtask

    // One uncontended access on port p followed by an idle cycle.
    task automatic single(input string tag, input int p, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic exp_err);
        logic [NP-1:0] onehot;
        onehot = NP'(1) << p;
        set_port(p, 1'b1, w, a, d);
        tick();
        check({tag, "_ack"}, 64'(ack), 64'(onehot));
        check({tag, "_err"}, 64'(addr_err), exp_err ? 64'(onehot) : 64'd0);
        set_port(p, 1'b0, 1'b0, '0, '0);
        tick();
        check({tag, "_idle"}, 64'(ack), 64'd0);
    endtask

    initial begin
        logic [NP-1:0] exp_seq [5];
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000;
        exp_seq[4] = 4'b0001;

        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        tick();
        tick();
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_err", 64'(addr_err), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic write then read back on port 0
        single("t1_wr", 0, 1'b1, 16'd5, 16'h1234, 1'b0);
        single("t1_rd", 0, 1'b0, 16'd5, 16'h0000, 1'b0);
        check("t1_rdata0", 64'(rd(0)), 64'h1234);

        // Bring pointer back to 0 via a port-3 access
        single("t2_pre", 3, 1'b0, 16'd5, 16'h0000, 1'b0);
        check("t2_rdata3", 64'(rd(3)), 64'h1234);

        // All ports hold read requests: 0,1,2,3 then 0 again
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b0, 16'd5, 16'h0000);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("t2_ack_c%0d", c + 1), 64'(ack), 64'(exp_seq[c]));
        end
        check("t2_rdata1", 64'(rd(1)), 64'h1234);
        check("t2_rdata2", 64'(rd(2)), 64'h1234);
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, 1'b0, '0, '0);
        tick();
        check("t2_idle", 64'(ack), 64'd0);

        // Pointer at 2 after port 1: port 3 beats port 0
        single("t3_p1", 1, 1'b0, 16'd5, 16'h0000, 1'b0);
        set_port(0, 1'b1, 1'b0, 16'd5, 16'h0000);
        set_port(3, 1'b1, 1'b0, 16'd5, 16'h0000);
        tick();
        check("t3_first", 64'(ack), 64'b1000);
        tick();
        check("t3_second", 64'(ack), 64'b0001);
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(3, 1'b0, 1'b0, '0, '0);
        tick();

        // Out-of-range: flagged, reads 0, write must not alias onto address 0
        single("t4_wr0", 2, 1'b1, 16'd0, 16'h5A5A, 1'b0);
        single("t4_rd_oob", 2, 1'b0, 16'd1024, 16'h0000, 1'b1);
        check("t4_rdata2_oob", 64'(rd(2)), 64'h0000);
        single("t4_wr_oob", 2, 1'b1, 16'd1024, 16'hDEAD, 1'b1);
        single("t4_rd0", 2, 1'b0, 16'd0, 16'h0000, 1'b0);
        check("t4_rdata2_mem0", 64'(rd(2)), 64'h5A5A);

        // Port 1 writes, port 3 reads the same word on the next cycle
        set_port(1, 1'b1, 1'b1, 16'd7, 16'hBEEF);
        tick();
        check("t5_wr_ack", 64'(ack), 64'b0010);
        set_port(1, 1'b0, 1'b0, '0, '0);
        set_port(3, 1'b1, 1'b0, 16'd7, 16'h0000);
        tick();
        check("t5_rd_ack", 64'(ack), 64'b1000);
        check("t5_rdata3", 64'(rd(3)), 64'hBEEF);
        check("t5_rdata1_held", 64'(rd(1)), 64'h1234);
        set_port(3, 1'b0, 1'b0, '0, '0);
        tick();

        // Move pointer off 0, start contention, then reset mid-stream
        single("t6_pre", 0, 1'b0, 16'd5, 16'h0000, 1'b0);
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b0, 16'd5, 16'h0000);
        tick();
        check("t6_before_rst", 64'(ack), 64'b0010);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ack", 64'(ack), 64'd0);
        check("t6_rst_rdata", 64'(rdata), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_first_grant", 64'(ack), 64'b0001);
        check("t6_rdata0_kept", 64'(rd(0)), 64'h1234);
        check("t6_err", 64'(addr_err), 64'd0);
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, 1'b0, '0, '0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
